// File: rtl/polar_freq_discriminator.sv
// rtl/polar_freq_discriminator.sv - wrapped phase-difference frequency discriminator with decimation and squelch
//
// Purpose: turns a stream of binary-angle phase / magnitude samples into a
// decimated instantaneous-frequency word. Each output is the signed sum of
// DECIM consecutive wrapped phase differences. Low-magnitude samples squelch
// the measurement and force a fresh prime.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            qualifies theta / r
//   theta               unsigned binary angle (2^PHASE_WIDTH counts per turn)
//   r                   unsigned magnitude
//   squelch_thresh      sample squelched when r < squelch_thresh
//   freq                signed sum of DECIM phase differences
//   out_valid/out_ready one-deep output handshake
//   squelch             last valid sample was squelched
//   overrun             sticky: a completed result was dropped

module polar_freq_discriminator #(
    parameter  int PHASE_WIDTH = 8,
    parameter  int MAG_WIDTH   = 17,
    parameter  int DECIM       = 4,
    localparam int OUT_WIDTH   = PHASE_WIDTH + $clog2(DECIM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [PHASE_WIDTH-1:0] theta,
    input  logic [MAG_WIDTH-1:0]   r,
    input  logic [MAG_WIDTH-1:0]   squelch_thresh,
    output logic [OUT_WIDTH-1:0]   freq,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   squelch,
    output logic                   overrun
);

    localparam int CNT_W = $clog2(DECIM);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                 r_state;
    logic [OUT_WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic [PHASE_WIDTH-1:0] r_theta_prev;

    logic                   w_squelched;
    logic [PHASE_WIDTH-1:0] w_diff;
    logic [OUT_WIDTH-1:0]   w_diff_ext;
    logic [OUT_WIDTH-1:0]   w_sum;
    logic                   w_last;
    logic                   w_result_valid;

    assign w_squelched = (r < squelch_thresh);

    // Modular subtraction gives the wrapped difference directly; reading the
    // result as two's complement maps a half-turn onto the negative extreme.
    assign w_diff     = theta - r_theta_prev;
    assign w_diff_ext = {{(OUT_WIDTH-PHASE_WIDTH){w_diff[PHASE_WIDTH-1]}}, w_diff};
    assign w_sum      = r_acc + w_diff_ext;

    // cnt counts completed differences modulo DECIM, so the DECIM-th one is
    // the difference arriving while cnt holds DECIM-1.
    assign w_last         = (r_cnt == CNT_W'(DECIM - 1));
    assign w_result_valid = in_valid && !w_squelched && (r_state == RUN) && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PRIME;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_theta_prev <= '0;
            freq         <= '0;
            out_valid    <= 1'b0;
            squelch      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (in_valid) begin
                if (w_squelched) begin
                    // Discard any partial block; the next good sample re-primes.
                    squelch <= 1'b1;
                    r_state <= PRIME;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else begin
                    squelch      <= 1'b0;
                    r_theta_prev <= theta;
                    r_state      <= RUN;
                    if (r_state == RUN) begin
                        if (w_last) begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            // One-deep output register: a result arriving while the previous
            // one is still unaccepted is dropped and flagged.
            if (w_result_valid) begin
                if (!out_valid || out_ready) begin
                    freq      <= w_sum;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_polar_freq_discriminator.sv
// tb/tb_polar_freq_discriminator.sv - self-checking bench for polar_freq_discriminator

module tb_polar_freq_discriminator;

    localparam int NOPIN = -100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  theta = '0;
    logic [16:0] r = '0;
    logic [16:0] squelch_thresh = 17'd100;
    logic [9:0]  freq;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        squelch;
    logic        overrun;

    always #5 clk = ~clk;

    polar_freq_discriminator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .theta          (theta),
        .r              (r),
        .squelch_thresh (squelch_thresh),
        .freq           (freq),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .squelch        (squelch),
        .overrun        (overrun)
    );

    // Behavioural model: remembers the previous accepted phase and the list
    // of wrapped differences in the current block; a block of four is summed.
    bit m_primed;
    int m_prev;
    int m_diffs[$];
    int m_freq, m_ov, m_ovr, m_sq;
    int m_d, m_res;
    bit m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_primed = 0;
            m_prev   = 0;
            m_diffs.delete();
            m_freq = 0; m_ov = 0; m_ovr = 0; m_sq = 0;
        end else begin
            m_done = 0;
            m_res  = 0;
            if (in_valid) begin
                if (int'(r) < int'(squelch_thresh)) begin
                    m_sq     = 1;
                    m_primed = 0;
                    m_diffs.delete();
                end else if (!m_primed) begin
                    m_prev   = int'(theta);
                    m_primed = 1;
                    m_sq     = 0;
                end else begin
                    m_d = (int'(theta) - m_prev) & 255;
                    if (m_d >= 128) m_d = m_d - 256;
                    m_diffs.push_back(m_d);
                    m_prev = int'(theta);
                    m_sq   = 0;
                    if (m_diffs.size() == 4) begin
                        foreach (m_diffs[i]) m_res = m_res + m_diffs[i];
                        m_diffs.delete();
                        m_done = 1;
                    end
                end
            end
            if (m_done) begin
                if (m_ov == 0 || out_ready) begin
                    m_freq = m_res;
                    m_ov   = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_ov == 1 && out_ready) begin
                m_ov = 0;
            end
        end
    end

    // Hand-computed expectations requested by the stimulus process; checked
    // by the compare process at the next falling edge.
    int pin_seq = 0;
    int pin_freq = NOPIN, pin_raw = -1, pin_ov = -1, pin_sq = -1, pin_ovr = -1, pin_pulses = -1;
    int last_seq = 0;
    int n_pulse = 0;
    int total = 0, bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("out_valid", int'(out_valid), m_ov);
        check("squelch", int'(squelch), m_sq);
        check("overrun", int'(overrun), m_ovr);
        check("freq", int'($signed(freq)), m_freq);
        if (out_valid && out_ready) n_pulse++;
        if (pin_seq != last_seq) begin
            last_seq = pin_seq;
            if (pin_freq != NOPIN) begin
                check("pin_freq_dut", int'($signed(freq)), pin_freq);
                check("pin_freq_model", m_freq, pin_freq);
            end
            if (pin_raw >= 0)    check("pin_freq_raw", int'(freq), pin_raw);
            if (pin_ov >= 0)     check("pin_out_valid", int'(out_valid), pin_ov);
            if (pin_sq >= 0)     check("pin_squelch", int'(squelch), pin_sq);
            if (pin_ovr >= 0)    check("pin_overrun", int'(overrun), pin_ovr);
            if (pin_pulses >= 0) check("pin_pulses", n_pulse, pin_pulses);
        end
    end

    task automatic pin(input int f, input int raw, input int ov, input int sq, input int ovr, input int pulses);
        pin_freq = f; pin_raw = raw; pin_ov = ov; pin_sq = sq; pin_ovr = ovr; pin_pulses = pulses;
        pin_seq++;
    endtask

    task automatic send(input int th, input int rr, input int rdy);
        @(negedge clk);
        #1;
        in_valid  = 1'b1;
        theta     = th[7:0];
        r         = rr[16:0];
        out_ready = rdy[0];
    endtask

    task automatic send5(input int a0, input int a1, input int a2, input int a3, input int a4);
        send(a0, 1000, 1); send(a1, 1000, 1); send(a2, 1000, 1);
        send(a3, 1000, 1); send(a4, 1000, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
    endtask

    int base;

    initial begin
        // Reset held with input activity
        for (int i = 0; i < 4; i++) send(i * 16, 1000, 1);
        pin(0, 0, 0, 0, 0, -1);
        idle(1);
        #1 rst_n = 1'b1;

        // Constant rotation, positive
        send(0, 50, 1);
        base = n_pulse;
        send5(0, 16, 32, 48, 64);
        pin(64, -1, 1, 0, 0, base + 1);
        idle(1);
        pin(64, -1, 0, -1, -1, base + 1);
        idle(1);

        // Constant rotation, negative
        send(0, 50, 1);
        send5(0, 240, 224, 208, 192);
        pin(-64, 10'h3C0, 1, 0, -1, -1);
        idle(2);

        // Wrap-around
        send(0, 50, 1);
        send5(250, 4, 14, 24, 34);
        pin(40, -1, 1, -1, -1, -1);
        idle(2);

        // Half-turn extreme
        send(0, 50, 1);
        send5(0, 128, 0, 128, 0);
        pin(-512, 10'h200, 1, -1, -1, -1);
        idle(2);

        // Squelch mid-block
        base = n_pulse;
        send(0, 1000, 1); send(16, 1000, 1); send(32, 1000, 1);
        send(48, 50, 1);
        pin(NOPIN, -1, 0, 1, -1, base);
        idle(1);
        send(100, 1000, 1);
        pin(NOPIN, -1, 0, 0, -1, base);
        idle(1);
        send(110, 1000, 1); send(120, 1000, 1); send(130, 1000, 1); send(140, 1000, 1);
        pin(40, -1, 1, 0, -1, base + 1);
        idle(2);

        // Threshold boundary
        send(0, 50, 1);
        send(0, 100, 1);
        pin(NOPIN, -1, -1, 0, -1, -1);
        idle(1);
        send(10, 99, 1);
        pin(NOPIN, -1, -1, 1, -1, -1);
        idle(1);

        // Reset mid-block: needs full prime plus four samples afterwards
        send(0, 50, 1);
        send(0, 1000, 1); send(16, 1000, 1); send(32, 1000, 1);
        reset_pulse();
        base = n_pulse;
        send(48, 1000, 1); send(64, 1000, 1); send(80, 1000, 1); send(96, 1000, 1);
        pin(0, -1, 0, 0, 0, base);
        idle(1);
        send(112, 1000, 1);
        pin(64, -1, 1, -1, -1, base + 1);
        idle(2);

        // Backpressure: second result dropped
        send(0, 50, 0);
        for (int i = 0; i <= 8; i++) send(i * 8, 1000, 0);
        pin(32, -1, 1, -1, 1, -1);
        idle(1);
        out_ready = 1'b1;
        pin(32, -1, 0, -1, 1, -1);
        idle(1);

        // Ready pulsed in the cycle the second result completes
        reset_pulse();
        out_ready = 1'b0;
        for (int i = 0; i <= 4; i++) send(i * 8, 1000, 0);
        pin(32, -1, 1, -1, 0, -1);
        idle(1);
        base = n_pulse;
        send(40, 1000, 0); send(48, 1000, 0); send(56, 1000, 0);
        send(64, 1000, 1);
        pin(32, -1, 1, -1, 0, base + 1);
        idle(1);
        pin(32, -1, 0, -1, 0, base + 1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/polar_freq_discriminator.md
# polar_freq_discriminator

Downstream consumer of the CORDIC cartesian-to-polar stage. Takes the stream of binary-angle phase (theta) and magnitude (r) samples and forms the wrapped phase difference between consecutive samples, which is the instantaneous frequency. It sums DECIM differences into one decimated frequency word and presents it on a valid/ready output. Samples whose magnitude is below a programmable threshold are squelched and restart the measurement.

## Interface
- PHASE_WIDTH, 8, theta width; binary angle, 2^PHASE_WIDTH counts = 2π (matches CORDIC ITERATIONS+1)
- MAG_WIDTH, 17, r width, unsigned (matches CORDIC DATA_WIDTH+1)
- DECIM, 4, phase differences summed per output word; power of two, ≥2
- OUT_WIDTH, PHASE_WIDTH+$clog2(DECIM), derived; not to be overridden
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  theta/r qualifier
- theta  in  PHASE_WIDTH  phase, unsigned binary angle
- r  in  MAG_WIDTH  magnitude
- squelch_thresh  in  MAG_WIDTH  sample is squelched when r < squelch_thresh; quasi-static
- freq  out  OUT_WIDTH  signed sum of DECIM phase differences
- out_valid  out  1  freq valid
- out_ready  in  1  downstream accepts freq
- squelch  out  1  last valid sample was squelched
- overrun  out  1  sticky; a result was dropped

## Operation
- The FSM has two states. PRIME is entered on reset and after any squelched sample. RUN is entered after a non-squelched sample is stored as the previous phase.
- Only cycles with in_valid=1 are processed. Gaps in in_valid have no effect on state.
- Squelched sample (r < squelch_thresh), in any state:
  - squelch←1
  - state←PRIME
  - acc←0, cnt←0; any partial block is discarded
  - theta is not stored
- Non-squelched sample in PRIME: theta_prev←theta, squelch←0, state←RUN. No difference is formed.
- Non-squelched sample in RUN:
  - d = (theta − theta_prev) mod 2^PHASE_WIDTH, interpreted as signed two's complement, so d is in [−2^(PHASE_WIDTH−1), 2^(PHASE_WIDTH−1)−1]. A difference of exactly half a turn maps to the negative extreme.
  - d is sign-extended to OUT_WIDTH and added to acc.
  - theta_prev←theta, squelch←0, cnt←cnt+1.
- When cnt reaches DECIM:
  - The result is acc + d, which always fits OUT_WIDTH; no saturation is needed.
  - acc←0, cnt←0, and the FSM stays in RUN. theta_prev carries over, so consecutive blocks share their boundary sample.
- Output register, one deep:
  - Register empty, or out_ready=1 in the same cycle: load the result and set out_valid=1.
  - out_valid=1 and out_ready=0: the new result is dropped, freq holds its value, and overrun←1.
  - overrun stays set until reset.
- When out_valid=1 and out_ready=1 with no new result in the same cycle, out_valid←0. freq keeps its last value.

## Timing
- Reset values: freq=0, out_valid=0, squelch=0, overrun=0, state=PRIME, acc=0, cnt=0, theta_prev=0.
- Reset assertion clears all state immediately and asynchronously, including mid-block and with a result pending. Deassertion is released on clk.
- Latency: out_valid rises on the clk edge that samples the DECIM-th difference (in_valid high in cycle N gives out_valid high in cycle N+1).
- squelch updates on the clk edge of the sample that determines it.
- The block accepts one input per cycle with no input backpressure. Minimum output spacing is DECIM input samples.
- out_valid and freq are stable while out_valid=1 and out_ready=0, except across reset.

## Test plan
All scenarios use default parameters, squelch_thresh=100, r=1000 unless stated, and out_ready=1 unless stated.
- Reset: hold rst_n=0 with input activity -> freq=0, out_valid=0, squelch=0, overrun=0. Pulse rst_n low mid-block -> the next output needs a full prime plus 4 samples.
- Constant rotation: theta 0,16,32,48,64 on consecutive cycles -> exactly one out_valid pulse, freq=64, on the cycle after theta=64. theta 0,240,224,208,192 -> freq=−64 (0x3C0).
- Wrap-around: theta 250,4,14,24,34 -> freq=40.
- Half-turn extreme: theta 0,128,0,128,0 -> each difference is −128, freq=−512 (0x200).
- Squelch mid-block: theta 0,16,32 (r=1000), then theta=48 with r=50, then theta 100,110,120,130,140 (r=1000):
  - squelch=1 after the r=50 sample and back to 0 after theta=100.
  - No output from the partial block.
  - One output with freq=40.
  - Boundary: r=100 is not squelched, r=99 is squelched.
- Backpressure: out_ready=0, then theta 0,8,...,64 in steps of 8 (two blocks):
  - First freq=32 is held.
  - Second result is dropped and overrun=1.
  - Raise out_ready -> out_valid falls the next cycle; overrun stays 1.
  - Repeat with out_ready pulsed in the cycle the second result completes -> no overrun, and freq=32 then 32 again.
